// File: rtl/cpu_bist_pkg.sv
// Shared definitions for the cpu self-test sequencer: opcodes, FSM states
// and the LFSR feedback step.
package cpu_bist_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } bist_state_t;

  // 8-bit maximal-length Fibonacci step, taps 8/6/5/4
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

endpackage

// File: rtl/cpu_bist_lfsr8.sv
// 8-bit LFSR with parallel load and a fixed number of steps per enable.
module lfsr8
  import cpu_bist_pkg::*;
#(
  parameter int         STEPS = 2,
  parameter logic [7:0] INIT  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] nxt;

  // chain STEPS feedback steps so one enable advances the sequence that far
  always_comb begin
    nxt = q;
    for (int i = 0; i < STEPS; i++) nxt = lfsr_step(nxt);
  end

  // load wins over advance; reset to a nonzero value so the LFSR never locks up
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= INIT;
    else if (load) q <= seed;
    else if (en)   q <= nxt;
  end

endmodule

// File: rtl/cpu_bist.sv
// Self-test initiator for the cpu datapath: drives LFSR operand pairs with
// alternating ADD/SUB, waits out the core latency and checks the result
// against an inline golden add/sub.
module cpu_bist
  import cpu_bist_pkg::*;
#(
  parameter int         NUM_VECTORS = 16,
  parameter int         LATENCY     = 1,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] result,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic       opcode,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail_idx
);

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);
  localparam logic [7:0] LAST_IDX  = 8'(NUM_VECTORS - 1);

  bist_state_t state;
  logic [7:0]  vec_idx;
  logic [3:0]  wait_cnt;
  logic [7:0]  expected;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_b;
  logic        lfsr_load;
  logic        lfsr_en;

  // reload on run acceptance, advance two steps per vector (one for a, one for b)
  assign lfsr_load = (state == S_IDLE) && start;
  assign lfsr_en   = (state == S_DRIVE);
  assign lfsr_b    = lfsr_step(lfsr_q);

  lfsr8 #(.STEPS(2), .INIT(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (reset),
    .load (lfsr_load),
    .seed (SEED),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  // sequencer: every output is registered; result is only looked at in CHECK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      vec_idx        <= '0;
      wait_cnt       <= '0;
      expected       <= '0;
      operand_a      <= '0;
      operand_b      <= '0;
      opcode         <= OP_ADD;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 8'hFF;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx        <= '0;
            err_count      <= '0;
            pass           <= 1'b0;
            first_fail_idx <= 8'hFF;
            busy           <= 1'b1;
            state          <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          operand_a <= lfsr_q;
          operand_b <= lfsr_b;
          opcode    <= vec_idx[0] ? OP_SUB : OP_ADD;
          expected  <= vec_idx[0] ? (lfsr_q - lfsr_b) : (lfsr_q + lfsr_b);
          wait_cnt  <= WAIT_INIT;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state    <= S_CHECK;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_CHECK: begin
          if (result != expected) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            // err_count only leaves zero on the first mismatch
            if (err_count == '0) first_fail_idx <= vec_idx;
          end
          if (vec_idx == LAST_IDX) begin
            state <= S_FINISH;
          end else begin
            vec_idx <= vec_idx + 8'd1;
            state   <= S_DRIVE;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bist.sv
// Bench for cpu_bist: four instances with different NUM_VECTORS/LATENCY,
// each driving a small cpu model (good, stuck-at-0, SUB-corrupting, or a
// deeper pipeline), checked against a run-level reference model.
module tb_cpu_bist;

  logic       clk;
  logic       reset;
  logic       start_r  [4];
  logic [7:0] res_w    [4];
  logic [7:0] oa_w     [4];
  logic [7:0] ob_w     [4];
  logic       op_w     [4];
  logic       busy_w   [4];
  logic       done_w   [4];
  logic       pass_w   [4];
  logic [7:0] err_w    [4];
  logic [7:0] ffi_w    [4];
  int         mode_r   [4];
  int         done_cnt [4];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ra [256];
  logic [7:0] rb [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cpu behaviour: 0 correct, 1 result stuck at 00, 2 SUB results off by one bit
  function automatic logic [7:0] cpu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic op, input int mode);
    logic [7:0] r;
    r = op ? a - b : a + b;
    if (mode == 1) r = 8'h00;
    if (mode == 2 && op) r = r ^ 8'h01;
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int NV    = (g == 1) ? 4 : 16;
    localparam int LAT   = (g == 2) ? 3 : 1;
    localparam int DEPTH = (g >= 2) ? 3 : 1;

    logic [7:0] pipe [3];

    always @(posedge clk) begin
      pipe[0] <= cpu_fn(oa_w[g], ob_w[g], op_w[g], mode_r[g]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign res_w[g] = (DEPTH == 1) ? pipe[0] : pipe[2];

    cpu_bist #(.NUM_VECTORS(NV), .LATENCY(LAT), .SEED(8'hA5)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start_r[g]),
      .result         (res_w[g]),
      .operand_a      (oa_w[g]),
      .operand_b      (ob_w[g]),
      .opcode         (op_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .pass           (pass_w[g]),
      .err_count      (err_w[g]),
      .first_fail_idx (ffi_w[g])
    );
  end

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int nv_of(input int g);  return (g == 1) ? 4 : 16; endfunction
  function automatic int lat_of(input int g); return (g == 2) ? 3 : 1;  endfunction

  // reference: LFSR sequence as a flat list, vector i uses entries 2i and 2i+1
  task automatic build_seq();
    logic [7:0] x;
    x = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      ra[i] = x; x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
      rb[i] = x; x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
  endtask

  task automatic ref_run(input int nv, input int mode, output int errs, output int first);
    logic [7:0] gold, got;
    errs = 0; first = 255;
    for (int i = 0; i < nv; i++) begin
      gold = (i % 2 == 1) ? ra[i] - rb[i] : ra[i] + rb[i];
      got  = gold;
      if (mode == 1) got = 8'h00;
      if (mode == 2 && (i % 2 == 1)) got = gold ^ 8'h01;
      if (got != gold) begin
        if (first == 255) first = i;
        errs++;
      end
    end
    if (errs > 255) errs = 255;
  endtask

  task automatic chk_reset_vals(input int g);
    chk($sformatf("rst_oa%0d", g),   oa_w[g],   0);
    chk($sformatf("rst_ob%0d", g),   ob_w[g],   0);
    chk($sformatf("rst_op%0d", g),   op_w[g],   0);
    chk($sformatf("rst_busy%0d", g), busy_w[g], 0);
    chk($sformatf("rst_done%0d", g), done_w[g], 0);
    chk($sformatf("rst_pass%0d", g), pass_w[g], 0);
    chk($sformatf("rst_err%0d", g),  err_w[g],  0);
    chk($sformatf("rst_ffi%0d", g),  ffi_w[g],  8'hFF);
  endtask

  // one full run on instance g; optionally pokes start mid-run
  task automatic run_one(input int g, input int mode, input bit poke);
    int nv, lat, len, cyc, pk, d0, errs, first;
    nv  = nv_of(g);
    lat = lat_of(g);
    len = 1 + nv * (lat + 2) + 1;
    ref_run(nv, mode, errs, first);
    mode_r[g] = mode;
    pk = $urandom_range(3, len - 3);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start_r[g] = 1'b1;
    d0  = done_cnt[g];
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      start_r[g] = poke && (cyc == pk);
      if (cyc == 2) chk($sformatf("busy_mid%0d", g), busy_w[g], 1);
      for (int v = 0; v < nv; v++)
        if (cyc == 2 + v * (lat + 2)) begin
          chk($sformatf("opa%0d_v%0d", g, v), oa_w[g], ra[v]);
          chk($sformatf("opb%0d_v%0d", g, v), ob_w[g], rb[v]);
          chk($sformatf("opc%0d_v%0d", g, v), op_w[g], v % 2);
        end
      if (done_w[g]) break;
    end
    start_r[g] = 1'b0;
    chk($sformatf("done_seen%0d", g), done_w[g], 1);
    chk($sformatf("run_len%0d", g),   cyc,       len);
    chk($sformatf("busy_end%0d", g),  busy_w[g], 0);
    if (g == 3) begin
      chk("lat_short_pass", pass_w[g], 0);
      chk("lat_short_err_nz", int'(err_w[g] != 0), 1);
    end else begin
      chk($sformatf("pass%0d_m%0d", g, mode), pass_w[g], int'(errs == 0));
      chk($sformatf("err%0d_m%0d", g, mode),  err_w[g],  errs);
      chk($sformatf("ffi%0d_m%0d", g, mode),  ffi_w[g],  first);
    end
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse%0d", g), done_w[g], 0);
    chk($sformatf("done_once%0d", g),  done_cnt[g] - d0, 1);
  endtask

  initial begin
    int d0;
    build_seq();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_r[i] = 1'b0; mode_r[i] = 0; done_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk_reset_vals(i);
    @(negedge clk);
    reset = 1'b0;

    // golden vectors: A5+4A=EF, 95-2A=6B
    chk("gold_v0", 8'(ra[0] + rb[0]), 8'hEF);
    chk("gold_v1", 8'(ra[1] - rb[1]), 8'h6B);

    run_one(0, 0, 1'b1);
    run_one(0, 2, 1'b0);
    run_one(1, 1, 1'b0);
    for (int k = 0; k < 4; k++) run_one($urandom_range(0, 1), $urandom_range(0, 2), 1'(k % 2));
    run_one(2, 0, 1'b1);
    run_one(3, 0, 1'b0);

    // reset while vector 3 of instance 0 is in WAIT
    mode_r[0] = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy_w[0], 1);
    chk("pre_rst_opa",  oa_w[0],   ra[3]);
    d0 = done_cnt[0];
    reset = 1'b1;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("no_done_after_rst", done_cnt[0] - d0, 0);
    run_one(0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
